sd4_mac_sequencer: RTL and testbench



---
 rtl/sd4_pkg.sv | 15 +
 rtl/sd4_pp_shift.sv | 25 ++
 rtl/sd4_mac_sequencer.sv | 125 ++++++++++++
 tb/tb_sd4_mac_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd4_pkg.sv
// Shared types and constants for the SD4 multiply-accumulate datapath.
package sd4_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } sd4_state_t;

    localparam int SD4_MAG_W = 37;
    localparam int SD4_EXP_W = 5;

    localparam logic [2:0] SD4_W_ZERO = 3'b111;

endpackage

// File: rtl/sd4_pp_shift.sv
// Combinational decode of one (image, weight) pair into sign, zero flag and
// exponent-shifted magnitude. Kept standalone so multi-lane arrays can reuse it.
module sd4_pp_shift
    import sd4_pkg::*;
(
    input  logic [7:0]           image,
    input  logic [3:0]           weight,
    output logic                 sign,
    output logic                 zero,
    output logic [SD4_MAG_W-1:0] mag
);

    logic [SD4_EXP_W-1:0] exp_sum;
    logic [SD4_MAG_W-1:0] base;

    // Sign/zero detection and the shift of the implicit-one mantissa by the summed exponent.
    always_comb begin
        sign    = image[7] ^ weight[0];
        zero    = (image[6:0] == 7'd0) | (weight[2:0] == SD4_W_ZERO);
        exp_sum = {1'b0, image[6:3]} + {2'b00, weight[3:1]};
        base    = {{(SD4_MAG_W-4){1'b0}}, 1'b1, image[2:0]};
        mag     = base << exp_sum;
    end

endmodule

// File: rtl/sd4_mac_sequencer.sv
// Vector framing, two-stage pipeline and output handshake for the SD4 MAC.
// Stage 1 registers the decoded pair, stage 2 folds it into the accumulator.
module sd4_mac_sequencer
    import sd4_pkg::*;
#(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       image,
    input  logic [3:0]       weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             busy
);

    localparam int               CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    sd4_state_t           state;
    logic [CNT_W-1:0]     count;
    logic                 in_hs;

    logic                 pp_sign;
    logic                 pp_zero;
    logic [SD4_MAG_W-1:0] pp_mag;

    logic                 s1_valid;
    logic                 s1_sign;
    logic                 s1_zero;
    logic [SD4_MAG_W-1:0] s1_mag;

    logic [ACC_W-1:0]     mag_ext;
    logic [ACC_W-1:0]     term;
    logic [ACC_W-1:0]     acc;

    sd4_pp_shift u_pp_shift (
        .image  (image),
        .weight (weight),
        .sign   (pp_sign),
        .zero   (pp_zero),
        .mag    (pp_mag)
    );

    assign in_ready = (state == ST_ACCUM) & ~rst & ~clr;
    assign in_hs    = in_valid & in_ready;
    assign out_acc  = acc;
    assign busy     = (state != ST_ACCUM) | (count != '0) | s1_valid;

    // Vector framing FSM: counts beats, spends one cycle draining stage 2, then holds the result.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            state     <= ST_ACCUM;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_hs) begin
                        if (count == LAST_IDX) begin
                            state <= ST_FLUSH;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 captures the decoded pair on every accepted beat; bubbles leave s1_valid low.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_sign <= pp_sign;
                s1_zero <= pp_zero;
                s1_mag  <= pp_mag;
            end
        end
    end

    // Turns the stage-1 magnitude into a signed two's-complement term at accumulator width.
    always_comb begin
        mag_ext = {{(ACC_W-SD4_MAG_W){1'b0}}, s1_mag};
        term    = '0;
        if (!s1_zero) begin
            term = s1_sign ? -mag_ext : mag_ext;
        end
    end

    // Stage 2 accumulates modulo 2^ACC_W and clears once the result has been taken.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            acc <= '0;
        end else if ((state == ST_DONE) && out_ready) begin
            acc <= '0;
        end else if (s1_valid) begin
            acc <= acc + term;
        end
    end

endmodule

// File: tb/tb_sd4_mac_sequencer.sv
// Scoreboard bench for sd4_mac_sequencer: a stimulus thread drives pairs,
// a negedge monitor models each accepted beat and compares presented results.
module tb_sd4_mac_sequencer;

    localparam int VEC_LEN = 4;
    localparam int ACC_W   = 48;

    typedef struct {
        logic [ACC_W-1:0] acc;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       image;
    logic [3:0]       weight;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             busy;

    int               checks   = 0;
    int               errors   = 0;
    int               cycle    = 0;
    int               pushed   = 0;
    int               dropped  = 0;
    int               seen     = 0;
    exp_t             expq[$];
    exp_t             popped;
    longint           model_sum   = 0;
    int               model_beats = 0;
    logic             mon_enable  = 1'b0;
    logic             prev_valid  = 1'b0;
    logic             prev_hs     = 1'b0;
    logic [ACC_W-1:0] prev_acc    = '0;
    logic [ACC_W-1:0] last_acc    = '0;
    logic             rand_ready  = 1'b0;

    sd4_mac_sequencer #(
        .VEC_LEN (VEC_LEN),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .image     (image),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .busy      (busy)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Cycle index used to check the result latency.
    always @(posedge clk) cycle <= cycle + 1;

    // Reference value of one pair, straight from the arithmetic definition of the decode.
    function automatic longint termOf(input logic [7:0] img, input logic [3:0] w);
        int     e;
        longint m;
        if (img[6:0] == 7'd0 || w[2:0] == 3'b111) return 0;
        e = int'(img[6:3]) + int'(w[3:1]);
        m = longint'(8 + int'(img[2:0])) * (longint'(1) << e);
        return (img[7] ^ w[0]) ? -m : m;
    endfunction

    // Single comparison point; every mismatch prints one FAIL line.
    task automatic checkOutput(input string name, input logic [ACC_W-1:0] actual,
                               input logic [ACC_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: checks presented results against the queue, then models accepted beats.
    always @(negedge clk) begin
        if (mon_enable) begin
            if (rst || clr) begin
                dropped     += expq.size();
                expq.delete();
                model_sum   = 0;
                model_beats = 0;
                prev_valid  = 1'b0;
                prev_hs     = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (expq.size() == 0) checkOutput("unexpected_out_valid", ACC_W'(out_valid), '0);
                    else checkOutput("latency", ACC_W'(cycle), ACC_W'(expq[0].due));
                end
                if (out_valid && prev_valid && !prev_hs) begin
                    checkOutput("out_acc_stable", out_acc, prev_acc);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checkOutput("spurious_result", ACC_W'(out_valid), '0);
                    end else begin
                        popped = expq.pop_front();
                        checkOutput("result", out_acc, popped.acc);
                        last_acc = out_acc;
                        seen++;
                    end
                end
                prev_valid = out_valid;
                prev_hs    = out_valid && out_ready;
                prev_acc   = out_acc;
                if (in_valid && in_ready) begin
                    model_sum += termOf(image, weight);
                    model_beats++;
                    if (model_beats == VEC_LEN) begin
                        expq.push_back('{acc: ACC_W'(model_sum), due: cycle + 2});
                        pushed++;
                        model_sum   = 0;
                        model_beats = 0;
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the randomized phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Drives one pair and holds it until accepted; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [7:0] img, input logic [3:0] w);
        int guard;
        image    = img;
        weight   = w;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", ACC_W'(in_ready), ACC_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Idle cycles with no beat offered.
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits, bounded, until every expected result has been presented and taken.
    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while ((expq.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) checkOutput({name, "_drain_timeout"}, ACC_W'(expq.size()), '0);
    endtask

    // Waits, bounded, for a result to appear while the consumer stalls.
    task automatic waitOutValid(input string name);
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!out_valid) checkOutput({name, "_valid_timeout"}, ACC_W'(out_valid), ACC_W'(1));
    endtask

    // One directed vector (beat k in byte/nibble k) followed by a check of its known sum.
    task automatic runVector(input string name, input logic [31:0] imgs, input logic [15:0] ws,
                             input bit bubble, input logic [ACC_W-1:0] expected);
        for (int k = 0; k < VEC_LEN; k++) begin
            applyStimulus(imgs[8*k +: 8], ws[4*k +: 4]);
            if (bubble) idle(1);
        end
        waitDrain(name);
        checkOutput({name, "_value"}, last_acc, expected);
    endtask

    // Main sequence: reset, directed cases, stalls, aborts, then a randomized stream.
    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        image     = '0;
        weight    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_in_rst", ACC_W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mon_enable = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", ACC_W'(in_ready), ACC_W'(1));
        checkOutput("reset_out_valid", ACC_W'(out_valid), '0);
        checkOutput("reset_out_acc", out_acc, '0);
        checkOutput("reset_busy", ACC_W'(busy), '0);
        @(posedge clk);
        #1;

        runVector("positive", 32'h09090909, 16'h2222, 1'b0, ACC_W'(144));
        runVector("sign_cancel", 32'h89098909, 16'h2222, 1'b0, '0);
        runVector("negative", 32'h09090909, 16'h3333, 1'b0, ACC_W'(-144));
        runVector("zero_mix", 32'h09098000, 16'h2722, 1'b0, ACC_W'(36));
        runVector("max_mag", 32'h7F7F7F7F, 16'hEEEE, 1'b0, ACC_W'(251658240));

        out_ready = 1'b0;
        for (int k = 0; k < VEC_LEN; k++) begin
            applyStimulus(8'h09, 4'h2);
            idle(1);
        end
        waitOutValid("stall");
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", ACC_W'(in_ready), '0);
            checkOutput("stall_out_valid", ACC_W'(out_valid), ACC_W'(1));
            checkOutput("stall_busy", ACC_W'(busy), ACC_W'(1));
        end
        checkOutput("stall_out_acc", out_acc, ACC_W'(144));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain("stall");
        runVector("after_stall", 32'h7F090909, 16'hE222, 1'b1, ACC_W'(62914560 + 108));

        applyStimulus(8'h7F, 4'hE);
        applyStimulus(8'h7F, 4'hE);
        clr = 1'b1;
        @(negedge clk);
        checkOutput("clr_in_ready", ACC_W'(in_ready), '0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        idle(6);
        checkOutput("clr_mid_no_out", ACC_W'(out_valid), '0);
        checkOutput("clr_mid_busy", ACC_W'(busy), '0);
        runVector("after_clr_mid", 32'h09098000, 16'h2722, 1'b0, ACC_W'(36));

        out_ready = 1'b0;
        for (int k = 0; k < VEC_LEN; k++) applyStimulus(8'h7F, 4'hE);
        waitOutValid("clr_done");
        clr = 1'b1;
        idle(1);
        clr       = 1'b0;
        out_ready = 1'b1;
        idle(4);
        checkOutput("clr_done_dropped", ACC_W'(out_valid), '0);
        runVector("after_clr_done", 32'h09090909, 16'h2222, 1'b0, ACC_W'(144));

        applyStimulus(8'h7F, 4'hE);
        applyStimulus(8'h7F, 4'hE);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_in_ready", ACC_W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        checkOutput("rst_mid_no_out", ACC_W'(out_valid), '0);
        runVector("after_rst", 32'h09090909, 16'h3333, 1'b0, ACC_W'(-144));

        rand_ready = 1'b1;
        for (int v = 0; v < 25; v++) begin
            for (int k = 0; k < VEC_LEN; k++) begin
                applyStimulus(8'($urandom), 4'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        waitDrain("random");

        checkOutput("result_count", ACC_W'(seen), ACC_W'(pushed - dropped));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
